// File: rtl/accel_regs_pkg.sv
// Register map, reset values, WHO_AM_I identity and FSM encoding shared by
// the LIS3DH-style SPI responder and its edge-sync front end.
package accel_regs_pkg;

  // register addresses (6-bit SPI address space)
  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_TEMP_CFG  = 6'h1F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

  localparam logic [7:0] WHO_AM_I_VAL   = 8'h33;

  localparam logic [7:0] RST_TEMP_CFG   = 8'h00;
  localparam logic [7:0] RST_CTRL_REG1  = 8'h07;
  localparam logic [7:0] RST_CTRL_REG4  = 8'h00;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // one acceleration sample, all three axes
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } sample_t;

  // only these three registers accept SPI writes
  function automatic logic is_writable(input logic [5:0] a);
    return (a == ADDR_TEMP_CFG) || (a == ADDR_CTRL_REG1) || (a == ADDR_CTRL_REG4);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// SPI front end: 2-flop synchronizers for SCK, CS_n and MOSI, plus edge
// detection on the synchronized SCK and CS_n.
//   clk_i, rst_i       : system clock, async active-high reset
//   sck_i, cs_n_i,
//   mosi_i             : raw asynchronous SPI pins
//   cs_n_o, mosi_o     : synchronized levels
//   sck_rise_o/fall_o  : one-cycle pulses on synchronized SCK edges
//   cs_fall_o/rise_o   : one-cycle pulses on synchronized CS_n edges
module spi_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic cs_n_o,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);

  logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic       sck_prev_q, cs_prev_q;

  // SCK resets to its idle-high level. CS_n resets to "selected" so that a
  // reset taken mid-transaction yields no CS fall until CS_n is seen high
  // again; the block then ignores the rest of the aborted frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= 2'b11;
      cs_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b1;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      cs_sync_q   <= {cs_sync_q[0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sck_prev_q  <= sck_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign cs_n_o     = cs_sync_q[1];
  assign mosi_o     = mosi_sync_q[1];
  assign sck_rise_o =  sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync_q[1] &  sck_prev_q;
  assign cs_fall_o  = ~cs_sync_q[1]  &  cs_prev_q;
  assign cs_rise_o  =  cs_sync_q[1]  & ~cs_prev_q;

endmodule

// File: rtl/lis3dh_spi_responder.sv
// SPI mode-3 register responder modelled on the LIS3DH accelerometer.
//   clk_in, rst          : system clock, async active-high reset
//   spi_sck/cs_n/mosi    : SPI initiator pins (asynchronous)
//   spi_miso             : read data, 0 while spi_cs_n is high
//   sample_x/y/z, sample_valid : new acceleration sample and load strobe
//   temp_cfg, ctrl_reg1, ctrl_reg4 : writable register contents
//   wr_strobe, wr_addr   : pulse and address of each committed write
module lis3dh_spi_responder
  import accel_regs_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic [7:0]  temp_cfg,
  output logic [7:0]  ctrl_reg1,
  output logic [7:0]  ctrl_reg4,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr
);

  logic cs_n_s, mosi_s, sck_rise, sck_fall, cs_fall, cs_rise;

  spi_edge_sync u_sync (
    .clk_i      (clk_in),
    .rst_i      (rst),
    .sck_i      (spi_sck),
    .cs_n_i     (spi_cs_n),
    .mosi_i     (spi_mosi),
    .cs_n_o     (cs_n_s),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_fall_o  (cs_fall),
    .cs_rise_o  (cs_rise)
  );

  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;     // first 7 bits of the byte in flight
  logic       rw_q, rw_d, ms_q, ms_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] miso_sh_q, miso_sh_d;
  logic       miso_q, miso_d;
  logic [7:0] tc_q, tc_d, c1_q, c1_d, c4_q, c4_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  sample_t    shadow_q, shadow_d, pend_smp_q, pend_smp_d;
  logic       pend_q, pend_d;

  logic [7:0] byte_in;
  logic [5:0] addr_nx;
  logic       bus_busy;

  function automatic logic [7:0] rd_mux(input logic [5:0] a, input logic [7:0] tc,
                                        input logic [7:0] c1, input logic [7:0] c4,
                                        input sample_t s);
    case (a)
      ADDR_WHO_AM_I:  rd_mux = WHO_AM_I_VAL;
      ADDR_TEMP_CFG:  rd_mux = tc;
      ADDR_CTRL_REG1: rd_mux = c1;
      ADDR_CTRL_REG4: rd_mux = c4;
      ADDR_OUT_X_L:   rd_mux = s.x[7:0];
      ADDR_OUT_X_H:   rd_mux = s.x[15:8];
      ADDR_OUT_Y_L:   rd_mux = s.y[7:0];
      ADDR_OUT_Y_H:   rd_mux = s.y[15:8];
      ADDR_OUT_Z_L:   rd_mux = s.z[7:0];
      ADDR_OUT_Z_H:   rd_mux = s.z[15:8];
      default:        rd_mux = 8'h00;
    endcase
  endfunction

  // ---------------- SPI protocol FSM ----------------
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ms_d        = ms_q;
    addr_d      = addr_q;
    miso_sh_d   = miso_sh_q;
    miso_d      = miso_q;
    tc_d        = tc_q;
    c1_d        = c1_q;
    c4_d        = c4_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    byte_in     = {shift_q, mosi_s};
    addr_nx     = ms_q ? addr_q + 6'd1 : addr_q;

    // MISO shifts on falling SCK so each bit is settled before the next rise
    if (state_q != ST_IDLE && sck_fall) begin
      miso_d    = miso_sh_q[7];
      miso_sh_d = {miso_sh_q[6:0], 1'b0};
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          shift_d   = '0;
          miso_sh_d = '0;
          miso_d    = 1'b0;
        end
      end
      ST_CMD: begin
        if (sck_rise) begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = byte_in[7];
            ms_d    = byte_in[6];
            addr_d  = byte_in[5:0];
            state_d = ST_DATA;
            // first read byte goes out starting with the next falling SCK
            if (byte_in[7])
              miso_sh_d = rd_mux(byte_in[5:0], tc_q, c1_q, c4_q, shadow_q);
          end
        end
      end
      ST_DATA: begin
        if (sck_rise) begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rw_q && is_writable(addr_q)) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = {1'b0, addr_q};
              case (addr_q)
                ADDR_TEMP_CFG:  tc_d = byte_in;
                ADDR_CTRL_REG1: c1_d = byte_in;
                ADDR_CTRL_REG4: c4_d = byte_in;
                default: ;
              endcase
            end
            addr_d = addr_nx;
            if (rw_q)
              miso_sh_d = rd_mux(addr_nx, tc_q, c1_q, c4_q, shadow_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CS_n high ends the frame; a partial byte is dropped (overrides commit)
    if (state_q != ST_IDLE && (cs_n_s || cs_rise)) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      miso_sh_d   = '0;
      miso_d      = 1'b0;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      tc_d        = tc_q;
      c1_d        = c1_q;
      c4_d        = c4_q;
    end
  end

  // ---------------- sample shadow / block data update ----------------
  // With BDU set, a sample arriving during a frame is parked (newest wins)
  // and copied into the shadow once the bus is idle, so a multi-byte read
  // never mixes halves of two samples.
  assign bus_busy = (state_q != ST_IDLE) || !cs_n_s;

  always_comb begin
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_smp_d = pend_smp_q;
    if (sample_valid) begin
      if (c4_q[7] && bus_busy) begin
        pend_d     = 1'b1;
        pend_smp_d = '{x: sample_x, y: sample_y, z: sample_z};
      end else begin
        shadow_d = '{x: sample_x, y: sample_y, z: sample_z};
        pend_d   = 1'b0;
      end
    end else if (pend_q && !bus_busy) begin
      shadow_d = pend_smp_q;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ms_q        <= 1'b0;
      addr_q      <= '0;
      miso_sh_q   <= '0;
      miso_q      <= 1'b0;
      tc_q        <= RST_TEMP_CFG;
      c1_q        <= RST_CTRL_REG1;
      c4_q        <= RST_CTRL_REG4;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      shadow_q    <= '0;
      pend_q      <= 1'b0;
      pend_smp_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ms_q        <= ms_d;
      addr_q      <= addr_d;
      miso_sh_q   <= miso_sh_d;
      miso_q      <= miso_d;
      tc_q        <= tc_d;
      c1_q        <= c1_d;
      c4_q        <= c4_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_smp_q  <= pend_smp_d;
    end
  end

  // gate with the raw pin so MISO drops the moment CS_n deasserts
  assign spi_miso  = miso_q & ~spi_cs_n;
  assign temp_cfg  = tc_q;
  assign ctrl_reg1 = c1_q;
  assign ctrl_reg4 = c4_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_lis3dh_spi_responder.sv
module tb_lis3dh_spi_responder;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b1, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  temp_cfg, ctrl_reg1, ctrl_reg4;
  logic        wr_strobe;
  logic [6:0]  wr_addr;

  lis3dh_spi_responder dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .spi_sck      (spi_sck),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .temp_cfg     (temp_cfg),
    .ctrl_reg1    (ctrl_reg1),
    .ctrl_reg4    (ctrl_reg4),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr)
  );

  always #5 clk_in = ~clk_in;

  localparam int HALF = 80;   // SCK half period: clk_in/16

  int n_chk = 0, n_pass = 0;
  int strobe_cnt = 0;

  // counts clk_in cycles with wr_strobe high, so a single write must add 1
  always @(negedge clk_in) if (wr_strobe) strobe_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sck = 1'b0; spi_mosi = tx[i];
      #HALF;
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      #HALF;
    end
  endtask

  task automatic cs_lo;
    spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_hi;
    #100;
    spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk_in);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    @(negedge clk_in);
    sample_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic       is_rd;
    logic [7:0] exp_rx;
    int         exp_stb;
    logic [6:0] exp_wa;
    logic [7:0] exp_tc;
    logic [7:0] exp_c1;
    logic [7:0] exp_c4;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [7:0] rx, rx2, rx3, rx4;
    int s0;

    //         cmd    dat    rd    rx     stb wa     tc     c1     c4
    vt[0]  = '{8'h8F, 8'h00, 1'b1, 8'h33, 0, 7'h00, 8'h00, 8'h07, 8'h00};
    vt[1]  = '{8'h20, 8'h77, 1'b0, 8'h00, 1, 7'h20, 8'h00, 8'h77, 8'h00};
    vt[2]  = '{8'hA0, 8'h00, 1'b1, 8'h77, 0, 7'h20, 8'h00, 8'h77, 8'h00};
    vt[3]  = '{8'h0F, 8'h55, 1'b0, 8'h00, 0, 7'h20, 8'h00, 8'h77, 8'h00};
    vt[4]  = '{8'h90, 8'h00, 1'b1, 8'h00, 0, 7'h20, 8'h00, 8'h77, 8'h00};
    vt[5]  = '{8'h8F, 8'h00, 1'b1, 8'h33, 0, 7'h20, 8'h00, 8'h77, 8'h00};
    vt[6]  = '{8'h1F, 8'hC0, 1'b0, 8'h00, 1, 7'h1F, 8'hC0, 8'h77, 8'h00};
    vt[7]  = '{8'h9F, 8'h00, 1'b1, 8'hC0, 0, 7'h1F, 8'hC0, 8'h77, 8'h00};
    vt[8]  = '{8'h23, 8'h05, 1'b0, 8'h00, 1, 7'h23, 8'hC0, 8'h77, 8'h05};
    vt[9]  = '{8'hA3, 8'h00, 1'b1, 8'h05, 0, 7'h23, 8'hC0, 8'h77, 8'h05};
    vt[10] = '{8'h11, 8'hFF, 1'b0, 8'h00, 0, 7'h23, 8'hC0, 8'h77, 8'h05};
    vt[11] = '{8'h28, 8'hAB, 1'b0, 8'h00, 0, 7'h23, 8'hC0, 8'h77, 8'h05};
    vt[12] = '{8'hA8, 8'h00, 1'b1, 8'h00, 0, 7'h23, 8'hC0, 8'h77, 8'h05};

    // ---- reset state ----
    repeat (3) @(negedge clk_in);
    chk("rst_ctrl_reg1", ctrl_reg1, 8'h07);
    chk("rst_temp_cfg", temp_cfg, 8'h00);
    chk("rst_ctrl_reg4", ctrl_reg4, 8'h00);
    chk("rst_wr_addr", wr_addr, 7'h00);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_miso", spi_miso, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk_in);

    // ---- table of two-byte transactions ----
    for (int i = 0; i < 13; i++) begin
      s0 = strobe_cnt;
      cs_lo;
      spi_byte(vt[i].cmd, 8, rx);
      spi_byte(vt[i].dat, 8, rx);
      cs_hi;
      if (vt[i].is_rd) chk($sformatf("v%0d_rx", i), rx, vt[i].exp_rx);
      chk($sformatf("v%0d_strobes", i), strobe_cnt - s0, vt[i].exp_stb);
      chk($sformatf("v%0d_wr_addr", i), wr_addr, vt[i].exp_wa);
      chk($sformatf("v%0d_temp_cfg", i), temp_cfg, vt[i].exp_tc);
      chk($sformatf("v%0d_ctrl_reg1", i), ctrl_reg1, vt[i].exp_c1);
      chk($sformatf("v%0d_ctrl_reg4", i), ctrl_reg4, vt[i].exp_c4);
    end
    chk("miso_idle", spi_miso, 1'b0);

    // ---- auto-increment burst write 0x1F, 0x20 ----
    s0 = strobe_cnt;
    cs_lo;
    spi_byte(8'h5F, 8, rx);
    spi_byte(8'hAA, 8, rx);
    spi_byte(8'hBB, 8, rx);
    cs_hi;
    chk("burst_temp_cfg", temp_cfg, 8'hAA);
    chk("burst_ctrl_reg1", ctrl_reg1, 8'hBB);
    chk("burst_strobes", strobe_cnt - s0, 2);
    chk("burst_wr_addr", wr_addr, 7'h20);

    // ---- sample readback, auto-increment over X and Y ----
    pulse_sample(16'h8001, 16'hBEEF, 16'h0000);
    cs_lo;
    spi_byte(8'hE8, 8, rx);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h00, 8, rx2);
    spi_byte(8'h00, 8, rx3);
    spi_byte(8'h00, 8, rx4);
    cs_hi;
    chk("out_x_l", rx, 8'h01);
    chk("out_x_h", rx2, 8'h80);
    chk("out_y_l", rx3, 8'hEF);
    chk("out_y_h", rx4, 8'hBE);

    // ---- BDU=1: sample mid-frame is deferred ----
    cs_lo; spi_byte(8'h23, 8, rx); spi_byte(8'h88, 8, rx); cs_hi;
    chk("bdu_ctrl_reg4", ctrl_reg4, 8'h88);
    cs_lo;
    spi_byte(8'hE8, 8, rx);
    pulse_sample(16'h1234, 16'hBEEF, 16'h0000);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h00, 8, rx2);
    cs_hi;
    chk("bdu_old_x_l", rx, 8'h01);
    chk("bdu_old_x_h", rx2, 8'h80);
    cs_lo;
    spi_byte(8'hE8, 8, rx);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h00, 8, rx2);
    cs_hi;
    chk("bdu_new_x_l", rx, 8'h34);
    chk("bdu_new_x_h", rx2, 8'h12);

    // ---- BDU=0: sample mid-frame lands immediately ----
    cs_lo; spi_byte(8'h23, 8, rx); spi_byte(8'h00, 8, rx); cs_hi;
    cs_lo;
    spi_byte(8'hE8, 8, rx);
    pulse_sample(16'h5678, 16'hBEEF, 16'h0000);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h00, 8, rx2);
    cs_hi;
    chk("nobdu_x_l", rx, 8'h34);
    chk("nobdu_x_h", rx2, 8'h56);

    // ---- aborted write: CS_n up after 5 data bits ----
    s0 = strobe_cnt;
    cs_lo;
    spi_byte(8'h20, 8, rx);
    spi_byte(8'h55, 5, rx);
    cs_hi;
    chk("abort_ctrl_reg1", ctrl_reg1, 8'hBB);
    chk("abort_strobes", strobe_cnt - s0, 0);
    cs_lo; spi_byte(8'h8F, 8, rx); spi_byte(8'h00, 8, rx); cs_hi;
    chk("abort_whoami", rx, 8'h33);

    // ---- reset mid-transaction: rest of frame ignored ----
    s0 = strobe_cnt;
    cs_lo;
    spi_byte(8'h20, 8, rx);
    @(negedge clk_in); rst = 1'b1;
    @(negedge clk_in); rst = 1'b0;
    spi_byte(8'h99, 8, rx);
    spi_byte(8'h42, 8, rx);
    cs_hi;
    chk("midrst_ctrl_reg1", ctrl_reg1, 8'h07);
    chk("midrst_strobes", strobe_cnt - s0, 0);
    chk("midrst_wr_addr", wr_addr, 7'h00);
    s0 = strobe_cnt;
    cs_lo; spi_byte(8'h20, 8, rx); spi_byte(8'h3C, 8, rx); cs_hi;
    chk("postrst_ctrl_reg1", ctrl_reg1, 8'h3C);
    chk("postrst_strobes", strobe_cnt - s0, 1);
    cs_lo; spi_byte(8'hE9, 8, rx); spi_byte(8'h00, 8, rx); cs_hi;
    chk("postrst_shadow", rx, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lis3dh_spi_responder.md
LIS3DH_SPI_RESPONDER -- requirements
Module: lis3dh_spi_responder

Interface
REQ-001 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 spi_sck  input  1  SPI clock from initiator, mode 3 (idles high, sample on rising, shift on falling); asynchronous to clk_in.
REQ-004 spi_cs_n  input  1  active-low chip select; asynchronous.
REQ-005 spi_mosi  input  1  serial data from initiator, MSB first; asynchronous.
REQ-006 spi_miso  output  1  serial data to initiator, MSB first; driven 0 while spi_cs_n high.
REQ-007 sample_x / sample_y / sample_z  input  16 each  new acceleration sample, two's complement.
REQ-008 sample_valid  input  1  one-cycle strobe; loads all sample_* values.
REQ-009 temp_cfg, ctrl_reg1, ctrl_reg4  output  8 each  current contents of registers 0x1F, 0x20, 0x23.
REQ-010 wr_strobe  output  1  one-cycle pulse per committed register write.
REQ-011 wr_addr  output  7  address of the last committed write.

Function
REQ-012 spi_sck, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchronizer; SCK edges SHALL be detected from the synchronized value; supported SCK frequency is at most clk_in/8.
REQ-013 FSM states SHALL be IDLE, CMD, DATA; any state SHALL return to IDLE within 3 clk_in cycles of spi_cs_n rising, discarding any partial byte.
REQ-014 IDLE -> CMD on synchronized spi_cs_n falling; bit counter cleared.
REQ-015 CMD SHALL shift 8 bits on rising SCK: bit7 = RW (1 = read), bit6 = MS (1 = auto-increment), bits5:0 = address; after the 8th bit -> DATA with address latched.
REQ-016 In DATA, for a read, the addressed register byte SHALL be loaded into the MISO shifter after the 8th rising SCK of the previous byte, and each bit driven on the following falling SCK edge, so that it is valid before the next rising edge.
REQ-017 In DATA, for a write, the byte SHALL be committed on its 8th rising SCK: register updated, wr_strobe high for exactly one cycle, wr_addr set.
REQ-018 After each complete data byte, the address SHALL increment when MS = 1 and hold when MS = 0; the 6-bit address wraps 0x3F -> 0x00.
REQ-019 Register map: 0x0F WHO_AM_I = 0x33 read-only; 0x1F TEMP_CFG rw (reset 0x00); 0x20 CTRL_REG1 rw (reset 0x07); 0x23 CTRL_REG4 rw (reset 0x00); 0x28-0x2D OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H read-only.
REQ-020 Unmapped addresses SHALL read 0x00; writes to read-only or unmapped addresses SHALL be ignored, with no wr_strobe.
REQ-021 OUT registers SHALL read from a shadow set loaded on sample_valid.
REQ-022 When CTRL_REG4[7] (BDU) = 1 and spi_cs_n is low, sample_valid SHALL be held pending and applied within 1 cycle after spi_cs_n returns to IDLE. Only the newest pending sample is kept.
REQ-023 With BDU = 0, sample_valid SHALL update the shadow immediately, even mid-transaction.
REQ-024 If sample_valid coincides with a write commit, both SHALL take effect in the same cycle.

Reset
REQ-025 On rst: FSM = IDLE, counters and shifters = 0, spi_miso = 0, wr_strobe = 0, wr_addr = 0, registers at the reset values in REQ-019, shadow OUT registers = 0, pending flag cleared.
REQ-026 If rst is asserted mid-transaction, the block SHALL ignore the remaining SCK edges until spi_cs_n is next seen high, then falling.

Structure
REQ-027 Package accel_regs_pkg SHALL hold the register addresses, reset values, the WHO_AM_I constant and the FSM state encoding.
REQ-028 One sub-module, spi_edge_sync, SHALL hold the synchronizers and the SCK rise/fall and CS fall/rise detection.

Verification
REQ-029 Send 0x8F then 0x00 (16 SCK) -> byte 2 on MISO = 0x33; no wr_strobe.
REQ-030 Send 0x20 0x77 -> ctrl_reg1 = 0x77, one wr_strobe, wr_addr = 0x20; then send 0xA0 0x00 -> MISO byte = 0x77.
REQ-031 Pulse sample_valid with sample_x = 0x8001; send 0xE8 plus 2 bytes -> MISO returns 0x01, then 0x80.
REQ-032 Set ctrl_reg4 = 0x88, open a read of 0xE8, pulse sample_valid with sample_x = 0x1234 between bytes -> old X returned; next transaction returns 0x34, 0x12.
REQ-033 Raise spi_cs_n after 5 data bits of a write to 0x20 -> ctrl_reg1 unchanged, no wr_strobe; the next 0x8F read returns 0x33.
REQ-034 Write 0x0F <- 0x55 and read 0x90 -> WHO_AM_I still reads 0x33, unmapped 0x10 reads 0x00, no wr_strobe.
